// File: rtl/cache_mem_arbiter.sv
// Purpose: shares one cacheline-wide memory port between icache and dcache, round-robin on ties.
// Latency: request sampled in IDLE -> memory strobe next cycle; resp combinational with dfp_resp.
// Backpressure: the losing requester holds its request and is guaranteed the next grant.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] dfp_addr,
  output logic              dfp_read,
  output logic              dfp_write,
  output logic [LINE_W-1:0] dfp_wdata,
  input  logic [LINE_W-1:0] dfp_rdata,
  input  logic              dfp_resp
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_owner;       // 0 = icache, 1 = dcache
  logic              r_last_owner;
  logic [ADDR_W-1:0] r_req_addr;
  logic [LINE_W-1:0] r_req_wdata;
  logic              r_req_is_write;
  logic              r_dfp_read;
  logic              r_dfp_write;

  logic w_i_req;
  logic w_d_req;
  logic w_any_req;
  logic w_grant_d;
  logic w_done;

  assign w_i_req   = i_read | i_write;
  assign w_d_req   = d_read | d_write;
  assign w_any_req = w_i_req | w_d_req;
  // dcache wins when alone, or on a tie when the icache held the port last
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_owner);
  assign w_done    = (r_state == S_BUSY) & dfp_resp;

  // Arbitration FSM: latch the winner in IDLE, hold it on the memory port until dfp_resp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_owner        <= 1'b0;
      r_last_owner   <= 1'b1;
      r_req_addr     <= '0;
      r_req_wdata    <= '0;
      r_req_is_write <= 1'b0;
      r_dfp_read     <= 1'b0;
      r_dfp_write    <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_any_req) begin
        // read+write together is treated as a write
        r_owner        <= w_grant_d;
        r_last_owner   <= w_grant_d;
        r_req_addr     <= w_grant_d ? d_addr  : i_addr;
        r_req_wdata    <= w_grant_d ? d_wdata : i_wdata;
        r_req_is_write <= w_grant_d ? d_write : i_write;
        r_dfp_read     <= w_grant_d ? ~d_write : ~i_write;
        r_dfp_write    <= w_grant_d ? d_write  : i_write;
        r_state        <= S_BUSY;
      end
    end else begin
      if (dfp_resp) begin
        r_dfp_read  <= 1'b0;
        r_dfp_write <= 1'b0;
        r_state     <= S_IDLE;
      end
    end
  end

  // Memory port is driven only from registers so requester changes cannot disturb it
  assign dfp_addr  = r_req_addr;
  assign dfp_wdata = r_req_wdata;
  assign dfp_read  = r_dfp_read  & ~r_req_is_write;
  assign dfp_write = r_dfp_write &  r_req_is_write;

  // Completion is steered to the owning cache only; read data is shared
  assign i_resp  = w_done & ~r_owner;
  assign d_resp  = w_done &  r_owner;
  assign i_rdata = dfp_rdata;
  assign d_rdata = dfp_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench: two cache requesters and a line memory drive the arbiter;
// a transaction-level model predicts grants, port contents and responses.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // requester side, index 0 = icache, 1 = dcache
  logic [AW-1:0] c_addr  [2];
  logic [LW-1:0] c_wdata [2];
  logic          c_rd    [2];
  logic          c_wr    [2];
  logic          c_cool  [2];

  logic [LW-1:0] i_rdata, d_rdata, dfp_wdata, dfp_rdata;
  logic          i_resp, d_resp, dfp_read, dfp_write, dfp_resp;
  logic [AW-1:0] dfp_addr;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_addr    (c_addr[0]),
    .i_read    (c_rd[0]),
    .i_write   (c_wr[0]),
    .i_wdata   (c_wdata[0]),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_addr    (c_addr[1]),
    .d_read    (c_rd[1]),
    .d_write   (c_wr[1]),
    .d_wdata   (c_wdata[1]),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .dfp_addr  (dfp_addr),
    .dfp_read  (dfp_read),
    .dfp_write (dfp_write),
    .dfp_wdata (dfp_wdata),
    .dfp_rdata (dfp_rdata),
    .dfp_resp  (dfp_resp)
  );

  // transaction-level model of what should be on the memory port
  bit            m_busy;
  bit            m_owner;
  bit            m_last;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  int            m_cnt;
  logic [LW-1:0] mem [logic [AW-1:0]];
  int            n_txn;
  int            n_grant [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return AW'(32'h0000_1000 + ($urandom_range(0, 15) << 5));
  endfunction

  // inputs for the current cycle, applied just after the rising edge
  task automatic drive_cycle();
    for (int p = 0; p < 2; p++) begin
      if (c_cool[p]) begin
        c_rd[p]   = 1'b0;
        c_wr[p]   = 1'b0;
        c_cool[p] = 1'b0;
      end else if (c_rd[p] || c_wr[p]) begin
        // the owner scrambles its inputs; the port must not follow them
        if (m_busy && int'(m_owner) == p) begin
          c_addr[p]  = rand_addr();
          c_wdata[p] = rand_line();
        end
      end else if ($urandom_range(0, 2) == 0) begin
        int kind;
        kind       = $urandom_range(0, 7);
        c_addr[p]  = rand_addr();
        c_wdata[p] = rand_line();
        c_wr[p]    = (kind <= 3);
        c_rd[p]    = (kind == 0) || (kind >= 4);
      end
    end
    if (m_busy) begin
      if (m_cnt == 0) begin
        dfp_resp  = 1'b1;
        dfp_rdata = m_we ? rand_line() : line_of(m_addr);
      end else begin
        m_cnt--;
        dfp_resp  = 1'b0;
        dfp_rdata = rand_line();
      end
    end else begin
      // stray responses while idle must be ignored
      dfp_resp  = ($urandom_range(0, 3) == 0);
      dfp_rdata = rand_line();
    end
  endtask

  // compare outputs mid-cycle against the model
  task automatic check_cycle();
    if (m_busy) begin
      chk("dfp_read",  LW'(dfp_read),  LW'(!m_we));
      chk("dfp_write", LW'(dfp_write), LW'(m_we));
      chk("dfp_addr",  LW'(dfp_addr),  LW'(m_addr));
      chk("dfp_wdata", dfp_wdata, m_wdata);
      chk("i_resp", LW'(i_resp), LW'(dfp_resp && !m_owner));
      chk("d_resp", LW'(d_resp), LW'(dfp_resp && m_owner));
      if (dfp_resp && !m_we) begin
        if (m_owner) chk("d_rdata", d_rdata, line_of(m_addr));
        else         chk("i_rdata", i_rdata, line_of(m_addr));
      end
    end else begin
      chk("idle_dfp_read",  LW'(dfp_read),  '0);
      chk("idle_dfp_write", LW'(dfp_write), '0);
      chk("idle_i_resp",    LW'(i_resp),    '0);
      chk("idle_d_resp",    LW'(d_resp),    '0);
    end
  endtask

  // advance the model across the next rising edge
  task automatic update_model();
    bit req0, req1, g;
    if (m_busy) begin
      if (dfp_resp) begin
        if (m_we) mem[m_addr] = m_wdata;
        m_busy          = 1'b0;
        m_last          = m_owner;
        c_cool[m_owner] = 1'b1;
        n_txn++;
      end
    end else begin
      req0 = c_rd[0] || c_wr[0];
      req1 = c_rd[1] || c_wr[1];
      if (req0 || req1) begin
        if (req0 && req1) g = !m_last;  // tie: whoever did not go last
        else              g = req1;
        m_owner = g;
        m_we    = c_wr[g];
        m_addr  = c_addr[g];
        m_wdata = c_wdata[g];
        m_cnt   = $urandom_range(0, 4);
        m_busy  = 1'b1;
        n_grant[g]++;
      end
    end
  endtask

  task automatic clear_model();
    m_busy = 1'b0;
    m_last = 1'b1;
    for (int p = 0; p < 2; p++) begin
      c_rd[p] = 1'b0; c_wr[p] = 1'b0; c_cool[p] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive_cycle();
    @(negedge clk);
    check_cycle();
    update_model();
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      c_addr[p] = '0; c_wdata[p] = '0;
    end
    clear_model();
    n_txn = 0; n_grant[0] = 0; n_grant[1] = 0; m_cnt = 0;
    m_owner = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    dfp_resp  = 1'b1;
    dfp_rdata = '0;

    // reset state, with a stray dfp_resp that must not leak through
    @(negedge clk);
    chk("rst_dfp_read",  LW'(dfp_read),  '0);
    chk("rst_dfp_write", LW'(dfp_write), '0);
    chk("rst_dfp_addr",  LW'(dfp_addr),  '0);
    chk("rst_dfp_wdata", dfp_wdata, '0);
    chk("rst_i_resp",    LW'(i_resp),    '0);
    chk("rst_d_resp",    LW'(d_resp),    '0);

    // both caches ask in the first cycle: icache must win the first tie
    @(posedge clk); #1;
    rst = 1'b0;
    dfp_resp  = 1'b0;
    c_rd[0] = 1'b1; c_addr[0] = 32'h0000_0100; c_wdata[0] = rand_line();
    c_rd[1] = 1'b1; c_addr[1] = 32'h0000_0200; c_wdata[1] = rand_line();
    @(negedge clk);
    check_cycle();
    update_model();

    repeat (3000) step();

    chk("txn_progress", LW'(n_txn >= 200), LW'(1));
    chk("both_served",  LW'(n_grant[0] > 20 && n_grant[1] > 20), LW'(1));

    // reach a BUSY cycle with no response pending, then reset mid-transaction
    for (int guard = 0; guard < 100; guard++) begin
      @(posedge clk); #1;
      drive_cycle();
      @(negedge clk);
      check_cycle();
      if (m_busy && !dfp_resp) break;
      update_model();
    end
    chk("reach_busy", LW'(m_busy && (dfp_read || dfp_write)), LW'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst_dfp_read",  LW'(dfp_read),  '0);
    chk("midrst_dfp_write", LW'(dfp_write), '0);
    chk("midrst_dfp_addr",  LW'(dfp_addr),  '0);
    clear_model();

    // late response after reset is ignored
    @(posedge clk); #1;
    rst = 1'b0;
    dfp_resp = 1'b1;
    @(negedge clk);
    check_cycle();
    update_model();

    // tie again after reset: icache first, then dcache
    @(posedge clk); #1;
    dfp_resp = 1'b0;
    c_rd[0] = 1'b1; c_wr[0] = 1'b0; c_addr[0] = 32'h0000_0300;
    c_rd[1] = 1'b1; c_wr[1] = 1'b0; c_addr[1] = 32'h0000_0400;
    @(negedge clk);
    check_cycle();
    update_model();
    chk("post_rst_tie_owner", LW'(m_owner), '0);
    repeat (30) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-requester arbiter that shares the single cacheline-wide memory port between the instruction cache and the data cache. It sits between both caches' downward-facing ports and the memory model/burst interface. It accepts one full-line read or write at a time, registers the winning request, and holds it on the memory port until `dfp_resp`. It steers the response back to the granted cache only. Ties are resolved round-robin so neither cache starves.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width; line-aligned addresses (`[4:0]` = 0) expected
- `LINE_W`, 256, cacheline width in bits

Ports:
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `i_addr`  in  ADDR_W  icache line address
- `i_read`  in  1  icache line read request, held until `i_resp`
- `i_write`  in  1  icache line write request (normally tied 0; supported)
- `i_wdata`  in  LINE_W  icache write line
- `i_rdata`  out  LINE_W  read line to icache
- `i_resp`  out  1  one-cycle completion pulse to icache
- `d_addr`, `d_read`, `d_write`, `d_wdata`, `d_rdata`, `d_resp`: same as `i_*`, for dcache
- `dfp_addr`  out  ADDR_W  memory address
- `dfp_read`  out  1  memory read strobe, held until `dfp_resp`
- `dfp_write`  out  1  memory write strobe, held until `dfp_resp`
- `dfp_wdata`  out  LINE_W  memory write line
- `dfp_rdata`  in  LINE_W  memory read line, valid with `dfp_resp`
- `dfp_resp`  in  1  memory completion, one cycle

## Operation
- State machine, two states:
  - IDLE: no memory transaction outstanding.
  - BUSY: one transaction on the memory port.
- Registers:
  - `state`
  - `owner` (0 = icache, 1 = dcache)
  - `last_owner`
  - `req_addr`, `req_wdata`, `req_is_write`
- A requester is "requesting" when its `read` or `write` is high.
- If `read` and `write` are both high on one port, this is illegal. The arbiter treats it as a write.
- IDLE behaviour:
  - Only one port requesting: grant it.
  - Both requesting: grant the port that is not `last_owner`.
  - Grant action: latch that port's addr, wdata and write flag; set `owner`, `last_owner` = granted port; go to BUSY.
  - No request: remain IDLE.
- BUSY behaviour:
  - `dfp_addr` = `req_addr`; `dfp_wdata` = `req_wdata`.
  - `dfp_read` = `!req_is_write`; `dfp_write` = `req_is_write`.
  - All four come from registers, never from requester inputs. Requester changes during BUSY do not disturb the memory port.
- Completion: on `dfp_resp` in BUSY:
  - Assert `i_resp` or `d_resp` for `owner` combinationally in that cycle; the other resp stays 0.
  - Next state IDLE.
- `i_rdata` and `d_rdata` are both wired directly to `dfp_rdata`. The data is only meaningful when the matching `resp` is high.
- `dfp_resp` in IDLE is ignored: no resp to either cache, no state change.
- Requester obligation: deassert `read`/`write` in the cycle after its `resp`. The arbiter may re-grant any request seen in that IDLE cycle.
- The non-granted requester keeps asserting its request. It is guaranteed the next grant.

## Timing
- Reset (async, immediate, independent of `clk`):
  - `state` = IDLE
  - `last_owner` = dcache, so the icache wins the first tie
  - `owner` = 0
  - `req_*` = 0
  - Outputs: `dfp_read` = `dfp_write` = 0, `dfp_addr` = 0, `dfp_wdata` = 0, `i_resp` = `d_resp` = 0
- Reset mid-BUSY: the transaction is abandoned and strobes drop at once. A late `dfp_resp` afterwards is ignored (state is IDLE).
- Grant latency: request sampled high at edge N (IDLE) → `dfp_read`/`dfp_write` high from cycle N+1.
- `resp` latency: same cycle as `dfp_resp`. Earliest turnaround is one IDLE cycle.
- Back-to-back transactions are spaced by at least 1 IDLE cycle: resp cycle → IDLE → BUSY.
- Worst-case wait for a requester: one full transaction of the other port.
- Memory strobes never glitch within BUSY. Exactly one of `dfp_read`/`dfp_write` is high in BUSY; both are 0 in IDLE.

## Test plan
- Reset, then icache read at 0x0000_1000 only; memory responds after 5 cycles with line A.
  - `dfp_read` = 1, `dfp_addr` = 0x1000 from the cycle after the request.
  - `i_resp` pulses once with `i_rdata` = A.
  - `d_resp` stays 0.
- Both caches request in the same cycle right after reset: icache read 0x100, dcache read 0x200.
  - Icache is served first.
  - Dcache is granted in the IDLE cycle after `i_resp`, with `dfp_addr` = 0x200.
- Both caches request again after a dcache-owned transaction: icache is granted. Repeat 4 times; grants must alternate.
- Dcache write at 0x0000_2040, wdata = all-0xA5; dcache changes `d_addr` mid-BUSY.
  - `dfp_write` = 1, `dfp_addr` stays 0x2040, `dfp_wdata` stays all-0xA5 until `dfp_resp`.
  - `d_resp` then pulses.
- Inject `dfp_resp` while IDLE: no resp and no state change. Assert `rst` mid-BUSY: `dfp_read` drops asynchronously.
- Illegal `d_read` = `d_write` = 1: a write is issued to memory.
